// File: rtl/instr_cache_set_refill.sv
// One E-way I-cache set with LRU replacement and a multi-beat L2 refill.
// Ports: clk/reset, ActiveSet/Flush/Block/Tag lookup, RepReq/RepValid/RepWord refill, Data/CacheSetMiss/RepDone out.
module instr_cache_set_refill #(
  parameter int B           = 64,
  parameter int NumTagBits  = 20,
  parameter int E           = 4,
  parameter int RefillWidth = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ActiveSet,
  input  logic                    Flush,
  input  logic [$clog2(B)-1:0]    Block,
  input  logic [NumTagBits-1:0]   Tag,
  input  logic                    RepValid,
  input  logic [RefillWidth-1:0]  RepWord,
  output logic [31:0]             Data,
  output logic                    CacheSetMiss,
  output logic                    RepReq,
  output logic                    RepDone
);
  localparam int Beats = B * 8 / RefillWidth;
  localparam int OffW  = $clog2(B);
  localparam int WayW  = $clog2(E);
  localparam int BeatW = $clog2(Beats);
  localparam int BitW  = $clog2(B * 8);
  localparam int RwW   = $clog2(RefillWidth);

  typedef enum logic {Idle, Fill} state_t;

  logic [B*8-1:0]        blockData [E];
  logic [NumTagBits-1:0] blockTag  [E];
  logic [E-1:0]          valid;
  logic [WayW-1:0]       age       [E];
  state_t                state;
  logic [BeatW-1:0]      beatCnt;
  logic [NumTagBits-1:0] repTag;
  logic [WayW-1:0]       victim;
  logic                  victimWasValid;

  logic                  hit;
  logic [WayW-1:0]       hitWay;
  logic [WayW-1:0]       newVictim;
  logic [BitW-1:0]       wordBit;
  logic [BitW-1:0]       beatBit;
  logic                  lastBeat;
  logic                  startFill;
  logic                  unusedBlockLsbs;

  assign unusedBlockLsbs = ^Block[1:0];
  assign wordBit = {Block[OffW-1:2], 5'd0};
  assign beatBit = {beatCnt, {RwW{1'b0}}};

  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = E - 1; w >= 0; w--) begin
      if (ActiveSet && valid[w] && blockTag[w] == Tag) begin
        hit    = 1'b1;
        hitWay = WayW'(w);
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest valid way.
  always_comb begin
    newVictim = '0;
    for (int w = E - 1; w >= 0; w--) begin
      if (age[w] == WayW'(E - 1)) newVictim = WayW'(w);
    end
    for (int w = E - 1; w >= 0; w--) begin
      if (!valid[w]) newVictim = WayW'(w);
    end
  end

  always_comb begin
    Data = '0;
    if (hit) Data = blockData[hitWay][wordBit +: 32];
  end

  assign CacheSetMiss = ~hit;
  assign lastBeat  = (state == Fill) && RepValid
                   && (beatCnt == BeatW'(Beats - 1));
  assign startFill = (state == Idle) && ActiveSet && !hit && !Flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid          <= '0;
      for (int w = 0; w < E; w++) age[w] <= WayW'(E - 1);
      state          <= Idle;
      beatCnt        <= '0;
      repTag         <= '0;
      victim         <= '0;
      victimWasValid <= 1'b0;
      RepReq         <= 1'b0;
      RepDone        <= 1'b0;
    end else begin
      RepDone <= 1'b0;
      if (Flush) begin
        valid   <= '0;
        for (int w = 0; w < E; w++) age[w] <= WayW'(E - 1);
        state   <= Idle;
        beatCnt <= '0;
        RepReq  <= 1'b0;
      end else begin
        // Hits in the commit cycle leave LRU to the fill update.
        if (hit && !lastBeat) begin
          for (int w = 0; w < E; w++) begin
            if (WayW'(w) == hitWay) begin
              age[w] <= '0;
            end else if (valid[w] && age[w] < age[hitWay]) begin
              age[w] <= age[w] + 1'b1;
            end
          end
        end
        unique case (state)
          Idle: begin
            if (startFill) begin
              state           <= Fill;
              repTag          <= Tag;
              victim          <= newVictim;
              victimWasValid  <= valid[newVictim];
              valid[newVictim] <= 1'b0;
              RepReq          <= 1'b1;
            end
          end
          Fill: begin
            if (RepValid) beatCnt <= beatCnt + 1'b1;
            if (lastBeat) begin
              valid[victim] <= 1'b1;
              beatCnt       <= '0;
              RepReq        <= 1'b0;
              RepDone       <= 1'b1;
              state         <= Idle;
              for (int w = 0; w < E; w++) begin
                if (WayW'(w) == victim) begin
                  age[w] <= '0;
                end else if (valid[w]) begin
                  if (!victimWasValid) begin
                    if (age[w] != WayW'(E - 1)) age[w] <= age[w] + 1'b1;
                  end else if (age[w] < age[victim]) begin
                    age[w] <= age[w] + 1'b1;
                  end
                end
              end
            end
          end
          default: state <= Idle;
        endcase
      end
    end
  end

  // Tag and data arrays carry no reset; Valid guards them.
  always_ff @(posedge clk) begin
    if (state == Fill && RepValid && !Flush) begin
      blockData[victim][beatBit +: RefillWidth] <= RepWord;
    end
    if (lastBeat && !Flush) begin
      blockTag[victim] <= repTag;
    end
  end
endmodule

// File: tb/tb_instr_cache_set_refill.sv
// Randomized bench for instr_cache_set_refill against a recency-list model.
// Drives lookups, refills, flushes and an async reset; compares every cycle.
module tb_instr_cache_set_refill;
  logic        clk = 1'b0;
  logic        reset;
  logic        ActiveSet;
  logic        Flush;
  logic [5:0]  Block;
  logic [19:0] Tag;
  logic        RepValid;
  logic [63:0] RepWord;
  logic [31:0] Data;
  logic        CacheSetMiss;
  logic        RepReq;
  logic        RepDone;

  instr_cache_set_refill dut (
    .clk(clk), .reset(reset), .ActiveSet(ActiveSet), .Flush(Flush),
    .Block(Block), .Tag(Tag), .RepValid(RepValid), .RepWord(RepWord),
    .Data(Data), .CacheSetMiss(CacheSetMiss), .RepReq(RepReq),
    .RepDone(RepDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: valid/tag/word arrays and an MRU-first list of valid ways.
  bit          mValid [4];
  logic [19:0] mTag   [4];
  logic [31:0] mData  [4][16];
  int          order[$];
  bit          mFill, mReq, mDone;
  int          mVic, mBeat;
  logic [19:0] mRepTag;

  function automatic void mRemove(int w);
    for (int i = 0; i < order.size(); i++)
      if (order[i] == w) begin order.delete(i); break; end
  endfunction

  function automatic void mClear();
    for (int w = 0; w < 4; w++) mValid[w] = 0;
    order.delete();
    mFill = 0; mReq = 0; mDone = 0; mBeat = 0;
  endfunction

  function automatic int mHitWay(bit act, logic [19:0] tg);
    if (!act) return -1;
    for (int w = 0; w < 4; w++)
      if (mValid[w] && mTag[w] == tg) return w;
    return -1;
  endfunction

  function automatic int mVictim();
    for (int w = 0; w < 4; w++) if (!mValid[w]) return w;
    return order[order.size() - 1];
  endfunction

  task automatic cycle(input bit act, input logic [19:0] tg,
                       input logic [5:0] blk, input bit fl,
                       input bit rv, input logic [63:0] wd);
    int hw;
    bit last;
    ActiveSet = act; Tag = tg; Block = blk;
    Flush = fl; RepValid = rv; RepWord = wd;
    @(negedge clk);
    hw = mHitWay(act, tg);
    check("miss", CacheSetMiss, 64'(hw < 0));
    check("data", Data, (hw < 0) ? 64'd0 : 64'(mData[hw][blk[5:2]]));
    check("repreq", RepReq, 64'(mReq));
    check("repdone", RepDone, 64'(mDone));
    @(posedge clk);
    mDone = 0;
    if (fl) mClear();
    else begin
      last = mFill && rv && mBeat == 7;
      if (hw >= 0 && !last) begin mRemove(hw); order.push_front(hw); end
      if (!mFill) begin
        if (act && hw < 0) begin
          mVic = mVictim(); mValid[mVic] = 0; mRemove(mVic);
          mFill = 1; mBeat = 0; mReq = 1; mRepTag = tg;
        end
      end else if (rv) begin
        mData[mVic][2*mBeat]   = wd[31:0];
        mData[mVic][2*mBeat+1] = wd[63:32];
        mBeat++;
        if (mBeat == 8) begin
          mValid[mVic] = 1; mTag[mVic] = mRepTag; order.push_front(mVic);
          mFill = 0; mBeat = 0; mReq = 0; mDone = 1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [63:0] pat(int k);
    return {32'(2 * k + 1), 32'(2 * k)};
  endfunction

  task automatic fillTag(input logic [19:0] tg);
    cycle(1, tg, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 1, {$urandom, $urandom});
  endtask

  logic [19:0] pool [6];

  initial begin
    pool[0] = 20'hA0001; pool[1] = 20'hB0002; pool[2] = 20'hC0003;
    pool[3] = 20'hD0004; pool[4] = 20'hE0005; pool[5] = 20'h12345;
    ActiveSet = 1; Tag = 20'h12345; Block = 0; Flush = 0;
    RepValid = 0; RepWord = 0; reset = 1;
    mClear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_miss", CacheSetMiss, 1);
    check("rst_req", RepReq, 0);
    check("rst_done", RepDone, 0);
    check("rst_data", Data, 0);
    reset = 0;

    // Cold miss, back-to-back beats.
    cycle(1, 20'h12345, 0, 0, 0, 0);
    check("cold_req_rise", RepReq, 1);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 1, pat(k));
    check("cold_done", RepDone, 1);
    cycle(1, 20'h12345, 6'h14, 0, 0, 0);
    check("cold_word5", Data, 5);

    // Gapped refill: same data must land.
    begin
      int k = 0;
      int i = 0;
      cycle(1, 20'h00ABC, 0, 0, 0, 0);
      while (k < 8) begin
        bit rv = (i % 2 == 0);
        cycle(0, 0, 0, 0, rv, rv ? pat(k) : {$urandom, $urandom});
        if (rv) k++;
        i++;
      end
      check("gap_done", RepDone, 1);
      for (int j = 0; j < 16; j++) begin
        cycle(1, 20'h00ABC, 6'(j * 4), 0, 0, 0);
        check("gap_word", Data, 64'(j));
      end
    end

    // LRU victim selection.
    cycle(0, 0, 0, 1, 0, 0);
    for (int t = 0; t < 4; t++) fillTag(pool[t]);
    cycle(1, pool[0], 0, 0, 0, 0);
    fillTag(pool[4]);
    cycle(1, pool[0], 0, 0, 0, 0);
    check("lru_A_hit", CacheSetMiss, 0);
    cycle(1, pool[2], 0, 0, 0, 0);
    check("lru_C_hit", CacheSetMiss, 0);
    cycle(1, pool[3], 0, 0, 0, 0);
    check("lru_D_hit", CacheSetMiss, 0);
    cycle(1, pool[1], 0, 0, 0, 0);
    check("lru_B_miss", CacheSetMiss, 1);

    // Flush on beat 5 of the B refill.
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 1, pat(k));
    cycle(0, 0, 0, 1, 1, pat(5));
    check("flush_req_drop", RepReq, 0);
    cycle(1, pool[0], 0, 0, 0, 0);
    check("flush_prior_miss", CacheSetMiss, 1);
    for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 1, pat(k));
    check("restart_no_early", RepDone, 0);
    cycle(0, 0, 0, 0, 1, pat(7));
    check("restart_done", RepDone, 1);

    // Flush colliding with the last beat discards the fill.
    cycle(1, pool[1], 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 1, pat(k));
    cycle(1, pool[1], 0, 1, 1, pat(7));
    check("flush_last_nodone", RepDone, 0);

    // Async reset mid-fill.
    fillTag(pool[2]);
    cycle(1, pool[3], 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1, pat(k));
    #2 reset = 1;
    #1;
    check("arst_req", RepReq, 0);
    check("arst_miss", CacheSetMiss, 1);
    @(posedge clk);
    #1 reset = 0;
    mClear();
    cycle(1, pool[2], 0, 0, 0, 0);
    cycle(1, pool[3], 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 1, pat(k));
    cycle(1, pool[2], 6'h14, 0, 0, 0);
    check("arst_refill_word5", Data, 5);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)],
            6'($urandom_range(0, 63)), $urandom_range(0, 59) == 0,
            $urandom_range(0, 2) != 0, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
